correlator_frame_packer: RTL and testbench

// - Downstream of the correlator core: frames each integration snapshot (counters + trailer fields) into a byte stream for the UART transmitter.
// - Snapshot is latched on a one-cycle capture strobe (integration edge already synchronised to clk).
// - Emits sync header, sequence byte, payload LSB-first and a check byte over a valid/ready byte interface.

---
 rtl/correlator_pkg.sv | 32 +++
 rtl/frame_check8.sv | 37 +++
 rtl/correlator_frame_packer.sv | 118 +++++++++++
 tb/tb_correlator_frame_packer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/correlator_pkg.sv
// Shared frame-packer types: frame state, sync word default, CRC-8 polynomial, helpers.
// No logic; types and pure functions only.
// Not applicable (no handshakes).
package correlator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_SEQ,
    ST_PAYLOAD,
    ST_CHECK
  } frame_state_e;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;
  localparam logic [7:0]  CRC8_POLY         = 8'h07;

  // Counter width for n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_check8.sv
// Frame check byte accumulator: CRC-8 (poly 0x07) when FRAME_CRC8_EN is defined, else additive sum.
// Latency: one cycle from byte_en to updated chk; clear wins over byte_en.
// Backpressure: none; caller pulses byte_en only on accepted bytes.
module frame_check8
  import correlator_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       byte_en,
  input  logic [7:0] data,
  output logic [7:0] chk
);

  logic [7:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (clear) begin
      chk_d = '0;
    end else if (byte_en) begin
`ifdef FRAME_CRC8_EN
      chk_d = crc8_next(chk_q, data);
`else
      chk_d = chk_q + data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_q <= '0;
    else        chk_q <= chk_d;
  end

  assign chk = chk_q;

endmodule

// File: rtl/correlator_frame_packer.sv
// Frames a latched correlator snapshot as SYNC(2) SEQ PAYLOAD(LSB byte first) CHECK over valid/ready.
// Latency: HDR0 is valid the cycle after an accepted capture; back-to-back frames have no gap.
// Backpressure: tx_byte held while tx_valid & !tx_ready; captures arriving mid-frame are dropped and counted.
module correlator_frame_packer
  import correlator_pkg::*;
#(
  parameter int          PAYLOAD_BITS = 2144,
  parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    capture,
  input  logic [PAYLOAD_BITS-1:0] snapshot,
  output logic [7:0]              tx_byte,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic [7:0]              overrun_cnt
);

  localparam int PAYLOAD_BYTES = PAYLOAD_BITS / 8;
  localparam int IDX_W = idx_width(PAYLOAD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  frame_state_e            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shadow_q, shadow_d;
  logic [7:0]              seq_q, seq_d;
  logic [7:0]              ovr_q, ovr_d;

  logic       hs, accept, drop, chk_en;
  logic [7:0] chk_val, byte_mux;

  always_comb begin
    byte_mux = 8'h00;
    case (state_q)
      ST_HDR0:    byte_mux = SYNC_WORD[15:8];
      ST_HDR1:    byte_mux = SYNC_WORD[7:0];
      ST_SEQ:     byte_mux = seq_q;
      ST_PAYLOAD: byte_mux = shadow_q[8*idx_q +: 8];
      ST_CHECK:   byte_mux = chk_val;
      default:    byte_mux = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    seq_d    = seq_q;
    ovr_d    = ovr_q;

    hs     = (state_q != ST_IDLE) && tx_ready;
    // A new capture may overlap only the final CHECK handshake of the running frame.
    accept = capture && enable && ((state_q == ST_IDLE) || ((state_q == ST_CHECK) && hs));
    drop   = capture && enable && !accept;
    chk_en = hs && ((state_q == ST_SEQ) || (state_q == ST_PAYLOAD));

    if (hs) begin
      case (state_q)
        ST_HDR0: state_d = ST_HDR1;
        ST_HDR1: state_d = ST_SEQ;
        ST_SEQ: begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
        end
        ST_PAYLOAD: begin
          if (idx_q == LAST_IDX) state_d = ST_CHECK;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          seq_d   = seq_q + 8'd1;
        end
        default: state_d = state_q;
      endcase
    end

    if (accept) begin
      state_d  = ST_HDR0;
      shadow_d = snapshot;
    end

    if (drop && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      seq_q    <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seq_q    <= seq_d;
      ovr_q    <= ovr_d;
    end
  end

  frame_check8 u_check (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .byte_en (chk_en),
    .data    (byte_mux),
    .chk     (chk_val)
  );

  assign tx_byte     = byte_mux;
  assign tx_valid    = (state_q != ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_correlator_frame_packer.sv
// Bench for correlator_frame_packer: queue-based frame model checked every cycle, plus a default-width frame.
// Build with or without FRAME_CRC8_EN; the model follows the same macro.
module tb_correlator_frame_packer;

  localparam int PB  = 32;
  localparam int PB2 = 2144;

  logic          clk;
  logic          rst_n;
  logic          enable, capture, tx_ready;
  logic [PB-1:0] snapshot;
  logic [7:0]    tx_byte, overrun_cnt;
  logic          tx_valid, busy;

  logic           cap2;
  logic [PB2-1:0] snap2;
  logic [7:0]     tx_byte2, ovr2;
  logic           tx_valid2, busy2;

  correlator_frame_packer #(.PAYLOAD_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .capture(capture), .snapshot(snapshot),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .overrun_cnt(overrun_cnt)
  );

  correlator_frame_packer dut2 (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .capture(cap2), .snapshot(snap2),
    .tx_byte(tx_byte2), .tx_valid(tx_valid2), .tx_ready(1'b1), .busy(busy2),
    .overrun_cnt(ovr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Check-byte fold: CRC as polynomial long division by x^8+x^2+x+1, or plain byte sum.
  function automatic logic [7:0] fold(input logic [7:0] acc, input logic [7:0] d);
`ifdef FRAME_CRC8_EN
    logic [15:0] v;
    v = {acc ^ d, 8'h00};
    for (int i = 15; i >= 8; i--) if (v[i]) v = v ^ (16'h0107 << (i - 8));
    return v[7:0];
`else
    return acc + d;
`endif
  endfunction

  typedef logic [7:0][7:0] frame8_t;

  function automatic frame8_t build8(input logic [7:0] s, input logic [31:0] snap);
    frame8_t f;
    logic [7:0] c;
    f[0] = 8'hA5;
    f[1] = 8'h5A;
    f[2] = s;
    c = fold(8'h00, s);
    for (int k = 0; k < 4; k++) begin
      f[3+k] = snap[8*k +: 8];
      c = fold(c, f[3+k]);
    end
    f[7] = c;
    return f;
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] m_seq, m_ovr, held;
  bit         stall, busy_m, hs_m, acc_m;
  frame8_t    fm;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_overrun", overrun_cnt, 0);
      exp_q.delete();
      m_seq = 0;
      m_ovr = 0;
      stall = 0;
    end else begin
      busy_m = (exp_q.size() != 0);
      chk("tx_valid", tx_valid, busy_m);
      chk("busy", busy, busy_m);
      chk("overrun_cnt", overrun_cnt, m_ovr);
      if (busy_m) chk("tx_byte", tx_byte, exp_q[0]);
      if (stall) chk("stall_hold", tx_byte, held);
      stall = busy_m && !tx_ready;
      held  = tx_byte;
      hs_m  = busy_m && tx_ready;
      acc_m = capture && enable && (!busy_m || (exp_q.size() == 1 && hs_m));
      if (hs_m) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_seq++;
      end
      if (capture && enable && !acc_m && m_ovr != 8'd255) m_ovr++;
      if (acc_m) begin
        fm = build8(m_seq, snapshot);
        for (int i = 0; i < 8; i++) exp_q.push_back(fm[i]);
      end
    end
  end

  task automatic step(input bit c, input bit e, input bit r);
    capture  = c;
    enable   = e;
    tx_ready = r;
    snapshot = $urandom();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step(0, 0, 1);
    rst_n = 1'b1;
    step(0, 0, 1);
  endtask

  task automatic drain();
    repeat (12) step(0, 1, 1);
  endtask

  frame8_t    pin_f;
  logic [7:0] pin_c;
  logic [7:0] e2[$];
  logic [7:0] got[$];
  int         nbad;

  initial begin
    rst_n = 1'b0; capture = 0; enable = 0; tx_ready = 1; snapshot = '0;
    cap2 = 0; snap2 = '0;

`ifdef FRAME_CRC8_EN
    pin_f = build8(8'h00, 32'h0);
    chk("pin_crc_zero_frame", pin_f, 64'h0000_0000_0000_5AA5);
    pin_c = 8'h00;
    for (int b = 8'h31; b <= 8'h39; b++) pin_c = fold(pin_c, 8'(b));
    chk("pin_crc_123456789", pin_c, 8'hF4);
`else
    pin_f = build8(8'h00, 32'h04030201);
    chk("pin_sum_frame", pin_f, 64'h0A04_0302_0100_5AA5);
    pin_c = fold(8'hF0, 8'h20);
    chk("pin_sum_wrap", pin_c, 8'h10);
`endif

    do_reset();

    // Directed frame with the documented snapshot.
    capture = 1; enable = 1; tx_ready = 1; snapshot = 32'h04030201;
    @(posedge clk); #1;
    drain();
    chk("idle_after_frame", busy, 0);

    // Directed all-zero snapshot.
    capture = 1; enable = 1; tx_ready = 1; snapshot = 32'h0;
    @(posedge clk); #1;
    drain();

    // Random captures, enables and backpressure.
    for (int t = 0; t < 600; t++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    drain();

    // Overrun: drops at HDR1 and mid-payload, a disabled capture is ignored.
    do_reset();
    step(1, 1, 1);
    step(0, 1, 1);
    step(1, 1, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    step(1, 1, 1);
    step(1, 0, 1);
    drain();
    chk("overrun_two", overrun_cnt, 2);
    step(1, 1, 1);
    drain();
    chk("model_seq_after_overrun", m_seq, 2);

    // Back-to-back frames, capture coincident with CHECK handshake; seq wraps.
    do_reset();
    for (int f = 0; f < 258; f++) begin
      step(1, 1, 1);
      repeat (7) step(0, 1, 1);
    end
    drain();
    chk("model_seq_wrapped", m_seq, 2);
    chk("b2b_no_overrun", overrun_cnt, 0);

    // Overrun saturation under a fully stalled frame.
    step(1, 1, 1);
    repeat (300) step(1, 1, 0);
    chk("overrun_saturated", overrun_cnt, 255);
    drain();

    // Reset mid-payload aborts the frame at once.
    do_reset();
    step(1, 1, 1);
    repeat (4) step(0, 1, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_valid", tx_valid, 0);
    chk("rst_mid_overrun", overrun_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 1, 1);
    step(1, 1, 1);
    drain();

    // Default-width frame: 2+1+268+1 bytes.
    for (int i = 0; i < PB2 / 32; i++) snap2[32*i +: 32] = $urandom();
    e2 = '{8'hA5, 8'h5A, 8'h00};
    pin_c = fold(8'h00, 8'h00);
    for (int k = 0; k < PB2 / 8; k++) begin
      e2.push_back(snap2[8*k +: 8]);
      pin_c = fold(pin_c, snap2[8*k +: 8]);
    end
    e2.push_back(pin_c);
    cap2 = 1;
    @(posedge clk); #1;
    cap2 = 0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (tx_valid2) got.push_back(tx_byte2);
      else if (got.size() != 0) break;
    end
    nbad = 0;
    for (int i = 0; i < got.size() && i < e2.size(); i++) if (got[i] !== e2[i]) nbad++;
    chk("long_frame_len", got.size(), 272);
    chk("long_frame_bytes", nbad, 0);
    chk("long_frame_idle", busy2, 0);
    chk("long_frame_overrun", ovr2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
